// File: rtl/or1300_pipe_pkg.sv
// Shared or1300 pipeline constants and the register-hazard-with-bypass helper.
package or1300_pipe_pkg;

    localparam int unsigned REG_ADDR_W       = 5;
    localparam int unsigned CID_W            = 4;
    localparam int unsigned DCACHE_REGADDR_W = 9;
    localparam int unsigned NUM_GPR          = 32;

    typedef logic [REG_ADDR_W-1:0] gpr_addr_t;
    typedef logic [CID_W-1:0]      cid_t;
    typedef logic [NUM_GPR-1:0]    gpr_mask_t;

    // A pending register is not a hazard if its write-back lands this cycle.
    function automatic logic reg_hazard(input gpr_mask_t mask,
                                        input gpr_addr_t r,
                                        input logic      byp_valid,
                                        input gpr_addr_t byp_reg);
        return mask[r] && !(byp_valid && (byp_reg == r));
    endfunction

endpackage

// File: rtl/hazard_check_port.sv
// Hazard evaluation for one ID register operand against the pending mask.
module hazard_check_port
    import or1300_pipe_pkg::*;
(
    input  logic      enable_i,
    input  gpr_addr_t addr_i,
    input  gpr_mask_t mask_i,
    input  logic      byp_valid_i,
    input  gpr_addr_t byp_reg_i,
    output logic      hazard_o
);

    always_comb begin
        hazard_o = enable_i && (addr_i != '0) &&
                   reg_hazard(mask_i, addr_i, byp_valid_i, byp_reg_i);
    end

endmodule

// File: rtl/load_hazard_scoreboard.sv
// Outstanding-load scoreboard for the current context: pending mask, count,
// ID-stage load-use/WAW stall with write-back bypass, and load throttling.
module load_hazard_scoreboard
    import or1300_pipe_pkg::*;
#(
    parameter int unsigned MAX_PENDING = 4,
    parameter int unsigned CNT_WIDTH   = 3
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [CID_W-1:0]            cid,
    input  logic                        exeLoadIssue,
    input  logic [REG_ADDR_W-1:0]       exeLoadDest,
    input  logic [REG_ADDR_W-1:0]       idOperantAAddr,
    input  logic [REG_ADDR_W-1:0]       idOperantBAddr,
    input  logic                        idUseImmediate,
    input  logic                        idIsJump,
    input  logic [2:0]                  idStore,
    input  logic                        idIsLoad,
    input  logic                        idWeDestination,
    input  logic [REG_ADDR_W-1:0]       idDestination,
    input  logic                        dcacheRegisterWe,
    input  logic [DCACHE_REGADDR_W-1:0] dcacheRegisterAddress,
    output logic                        hazardStall,
    output logic [NUM_GPR-1:0]          pendingMask,
    output logic [CNT_WIDTH-1:0]        pendingCount,
    output logic                        protocolError
);

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_PENDING);

    gpr_mask_t             mask_q, mask_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  err_q, err_d;

    logic      complete;
    gpr_addr_t comp_reg;
    logic      set;
    logic      same_reg;
    logic      set_hit;
    logic      comp_hit;
    logic      inc;
    logic      dec;
    logic      hz_a, hz_b, hz_d;

    always_comb begin
        complete = dcacheRegisterWe &&
                   (dcacheRegisterAddress[DCACHE_REGADDR_W-1:REG_ADDR_W] == cid);
        comp_reg = dcacheRegisterAddress[REG_ADDR_W-1:0];
        set      = exeLoadIssue && (exeLoadDest != '0);
        same_reg = set && complete && (exeLoadDest == comp_reg);
        set_hit  = set && mask_q[exeLoadDest];
        comp_hit = complete && mask_q[comp_reg];
        inc      = set && !set_hit;
        // A retiring entry immediately re-issued keeps its bit and its count.
        dec      = comp_hit && !same_reg;
    end

    always_comb begin
        mask_d = mask_q;
        if (comp_hit) mask_d[comp_reg] = 1'b0;
        if (set)      mask_d[exeLoadDest] = 1'b1;

        count_d = count_q;
        if (inc && !dec) begin
            count_d = (count_q == MAX_CNT) ? count_q : count_q + CNT_WIDTH'(1);
        end else if (dec && !inc) begin
            count_d = (count_q == '0) ? count_q : count_q - CNT_WIDTH'(1);
        end

        err_d = err_q
              | (set_hit && !same_reg)
              | (complete && !mask_q[comp_reg])
              | (inc && (count_q == MAX_CNT) && !comp_hit);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mask_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    hazard_check_port u_hz_a (
        .enable_i    (!idIsJump),
        .addr_i      (idOperantAAddr),
        .mask_i      (mask_q),
        .byp_valid_i (complete),
        .byp_reg_i   (comp_reg),
        .hazard_o    (hz_a)
    );

    hazard_check_port u_hz_b (
        .enable_i    (!idUseImmediate || (idStore != '0)),
        .addr_i      (idOperantBAddr),
        .mask_i      (mask_q),
        .byp_valid_i (complete),
        .byp_reg_i   (comp_reg),
        .hazard_o    (hz_b)
    );

    hazard_check_port u_hz_d (
        .enable_i    (idWeDestination),
        .addr_i      (idDestination),
        .mask_i      (mask_q),
        .byp_valid_i (complete),
        .byp_reg_i   (comp_reg),
        .hazard_o    (hz_d)
    );

    always_comb begin
        hazardStall = hz_a || hz_b || hz_d ||
                      (idIsLoad && (count_q == MAX_CNT) && !complete);
    end

    assign pendingMask   = mask_q;
    assign pendingCount  = count_q;
    assign protocolError = err_q;

endmodule
